// File: rtl/data_sync_arb_pkg.sv
`default_nettype none
// ============================================================================
// data_sync_pkg : shared types and default constants for data_sync_arb
// Rev 1.0
// ============================================================================
package data_sync_pkg;

    localparam int DEF_BUS_WIDTH   = 8;
    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_HOLD_CYCLES = 4;
    localparam int DEF_GAP_CYCLES  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_sync_arb_if.sv
`default_nettype none
// ============================================================================
// data_sync_arb_if : requester/arbiter bus bundle toward DATA_SYNC
// Rev 1.0
// ============================================================================
interface data_sync_arb_if
    import data_sync_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH,
    parameter int NUM_REQ   = DEF_NUM_REQ
) ();

    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*BUS_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]           grant;
    logic [NUM_REQ-1:0]           done;
    logic [BUS_WIDTH-1:0]         Unsync_bus;
    logic                         bus_enable;
    logic                         busy;

    modport master (
        output req, req_data,
        input  grant, done, Unsync_bus, bus_enable, busy
    );

    modport slave (
        input  req, req_data,
        output grant, done, Unsync_bus, bus_enable, busy
    );

endinterface
`default_nettype wire

// File: rtl/data_sync_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// sync_rr_pick : combinational round-robin select starting after last_grant
// Rev 1.0
// ============================================================================
module sync_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = 2
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [IDXW-1:0]    i_last_grant,
    output logic      [NUM_REQ-1:0] o_winner,
    output logic                    o_valid
);

    logic [IDXW-1:0] w_k;

    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_k      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_k = IDXW'((int'(i_last_grant) + off) % NUM_REQ);
            if (!o_valid && i_req[w_k]) begin
                o_winner[w_k] = 1'b1;
                o_valid       = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_sync_arb.sv
`default_nettype none
// ============================================================================
// data_sync_arb : round-robin arbiter feeding a held word + enable to DATA_SYNC
// Rev 1.0
// ============================================================================
module data_sync_arb
    import data_sync_pkg::*;
#(
    parameter int BUS_WIDTH   = DEF_BUS_WIDTH,
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  wire logic      clk,
    input  wire logic      rst,
    data_sync_arb_if.slave bus
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNTW = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES)) + 1;

    localparam logic [CNTW-1:0] C_HOLD_LOAD = CNTW'(HOLD_CYCLES - 1);
    localparam logic [CNTW-1:0] C_GAP_LOAD  = CNTW'(GAP_CYCLES - 1);
    localparam logic [CNTW-1:0] C_CNT_ONE   = CNTW'(1);
    localparam logic [IDXW-1:0] C_LAST_RST  = IDXW'(NUM_REQ - 1);

    state_t               r_state, w_state_nxt;
    logic [CNTW-1:0]      r_cnt, w_cnt_nxt;
    logic [IDXW-1:0]      r_last, w_last_nxt, w_win_idx;
    logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0]   r_done, w_done_nxt;
    logic [NUM_REQ-1:0]   w_win;
    logic [BUS_WIDTH-1:0] r_bus, w_bus_nxt, w_win_data;
    logic                 r_en, w_en_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 w_valid;

    sync_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_pick (
        .i_req        (bus.req),
        .i_last_grant (r_last),
        .o_winner     (w_win),
        .o_valid      (w_valid)
    );

    always_comb begin
        w_win_idx  = '0;
        w_win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_win[k]) begin
                w_win_idx  = IDXW'(k);
                w_win_data = bus.req_data[k*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The counter is reloaded on every state entry, so it only ever counts down to zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = C_HOLD_LOAD;
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = GAP;
                    w_cnt_nxt   = C_GAP_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - C_CNT_ONE;
                end
            end
            GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - C_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are precomputed here and registered so every port comes off a flop.
    always_comb begin
        w_grant_nxt = '0;
        w_done_nxt  = '0;
        w_en_nxt    = (w_state_nxt == HOLD);
        w_busy_nxt  = (w_state_nxt != IDLE);
        w_bus_nxt   = r_bus;
        w_last_nxt  = r_last;
        if (r_state == IDLE && w_valid) begin
            w_grant_nxt = w_win;
            w_bus_nxt   = w_win_data;
            w_last_nxt  = w_win_idx;
        end
        if (w_state_nxt == GAP && w_cnt_nxt == '0) begin
            w_done_nxt = NUM_REQ'(1) << r_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant <= '0;
            r_done  <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_bus   <= '0;
            r_last  <= C_LAST_RST;
        end else begin
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_en    <= w_en_nxt;
            r_busy  <= w_busy_nxt;
            r_bus   <= w_bus_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign bus.grant      = r_grant;
    assign bus.done       = r_done;
    assign bus.bus_enable = r_en;
    assign bus.busy       = r_busy;
    assign bus.Unsync_bus = r_bus;

endmodule
`default_nettype wire

// File: doc/data_sync_arb.md
DATA_SYNC_ARB -- requirements
Module: data_sync_arb

Interface
REQ-001 Parameter BUS_WIDTH, default 8, width of each requester word and of Unsync_bus.
REQ-002 Parameter NUM_REQ, default 4, number of requesters (legal range 2..16).
REQ-003 Parameter HOLD_CYCLES, default 4, clk cycles bus_enable stays high per transfer (legal range >=1).
REQ-004 Parameter GAP_CYCLES, default 2, clk cycles bus_enable stays low after HOLD with data still stable (legal range >=1).
REQ-005 clk  input  1  single clock; all logic is rising-edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 req  input  NUM_REQ  per-requester transfer request, level, held until grant.
REQ-008 req_data  input  NUM_REQ*BUS_WIDTH  packed words, requester k at bits [k*BUS_WIDTH +: BUS_WIDTH].
REQ-009 grant  output  NUM_REQ  one-hot, one-cycle acceptance pulse; requester may drop req/data afterwards.
REQ-010 done  output  NUM_REQ  one-hot, one-cycle completion pulse for the granted requester.
REQ-011 Unsync_bus  output  BUS_WIDTH  registered word toward the DATA_SYNC input.
REQ-012 bus_enable  output  1  registered enable toward DATA_SYNC.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states are IDLE, HOLD and GAP; one transfer runs at a time.
REQ-015 IDLE with req==0: remain IDLE, all pulse outputs 0, Unsync_bus unchanged.
REQ-016 IDLE with any req bit set at cycle t: winner chosen round-robin starting at index (last_grant+1) mod NUM_REQ, wrapping.
REQ-017 At edge t+1: state=HOLD, Unsync_bus=req_data of winner, grant=one-hot winner for exactly that cycle, bus_enable=1, last_grant=winner.
REQ-018 bus_enable stays 1 for exactly HOLD_CYCLES cycles (t+1..t+HOLD_CYCLES), then state=GAP.
REQ-019 GAP: bus_enable=0 for exactly GAP_CYCLES cycles; Unsync_bus unchanged throughout HOLD and GAP.
REQ-020 done[winner]=1 on the last GAP cycle only; next cycle state=IDLE and arbitration may occur in that same IDLE cycle.
REQ-021 Minimum grant-to-grant spacing is HOLD_CYCLES+GAP_CYCLES+1 cycles.
REQ-022 req bits asserted or changed during HOLD/GAP are ignored until IDLE; req dropped before grant is never granted.
REQ-023 A single down-counter, width $clog2(max(HOLD_CYCLES,GAP_CYCLES))+1, is loaded on each state entry and never wraps.
REQ-024 grant and done are never asserted in the same cycle; at most one bit of each is set.
REQ-025 System rule: HOLD_CYCLES and GAP_CYCLES each cover at least NUM_STAGES+1 destination clk periods.

Reset
REQ-026 rst high at an edge forces state=IDLE, Unsync_bus=0, bus_enable=0, grant=0, done=0, busy=0, counter=0.
REQ-027 Reset sets last_grant=NUM_REQ-1 so requester 0 has top priority first.
REQ-028 rst mid-transfer aborts it with no done pulse; the requester must re-request.
REQ-029 rst has priority over every FSM transition in the same cycle.

Structure
REQ-030 Package data_sync_pkg holds the state enum (IDLE, HOLD, GAP) and default constants for BUS_WIDTH, NUM_REQ, HOLD_CYCLES, GAP_CYCLES.
REQ-031 One sub-module, sync_rr_pick: combinational round-robin select taking req and last_grant, returning a one-hot winner and a valid flag.
REQ-032 FSM, counter, data register and pointer live in data_sync_arb; outputs are driven only from registers.

Verification (NUM_REQ=4, HOLD=4, GAP=2, BUS_WIDTH=8)
REQ-033 rst for 2 cycles with req=4'hF -> all outputs 0 and busy=0 during reset; first grant after release is 4'b0001.
REQ-034 req=4'b0010, req_data[15:8]=8'hA5 at cycle 0 -> grant=0010 at cycle 1, bus_enable=1 at cycles 1-4 and 0 at 5-6, Unsync_bus=8'hA5 at 1-6, done=0010 at 6, busy=0 at 7.
REQ-035 req=4'hF held continuously -> grants 0001,0010,0100,1000,0001 at cycles 1,8,15,22,29.
REQ-036 req0 granted at cycle 1, req2 raised at cycle 3 -> req2 granted at cycle 8 with its data; no grant inside cycles 2-7.
REQ-037 rst pulsed at cycle 3 of a req1 transfer -> cycle 4 all outputs 0, no done[1]; req1 still high -> granted at cycle 5.
REQ-038 req3 raised at cycle 2 and dropped at cycle 5 during a req0 transfer -> req3 never granted, bus idle after cycle 6.
